muxn_pipe_stage: RTL and testbench
==================================

# muxn_pipe_stage

Parametrised N-way, WIDTH-bit selection stage with a registered, valid/ready-handshaked output and a two-entry skid buffer. It replaces bare combinational 2:1 data selectors on pipeline-stage boundaries, such as operand forwarding, PC-source and writeback-source selection, where the selected value must be registered. It also supports backpressure (stall) and flush without combinational ready paths.

## Interface
- WIDTH, 32, data width of each channel and of the output.
- N, 2, number of input channels (N ≥ 2; not required to be a power of two).
- SEL_W, $clog2(N), select width (derived localparam, not overridable).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  N*WIDTH  channel k at bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  binary channel select, sampled with in_data.
- in_valid  in  1  producer offers in_data/sel.
- in_ready  out  1  stage accepts; registered (no combinational path from out_ready).
- flush  in  1  synchronous discard of all held entries.
- out_data  out  WIDTH  selected, registered data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- sel_err  out  1  one-cycle registered pulse when an accepted sel ≥ N.

## Operation
- Transfer in: in_valid & in_ready, sampled at a rising edge. Transfer out: out_valid & out_ready.
- Selected value is in_data[sel*WIDTH +: WIDTH]. If sel ≥ N, channel 0 is selected and sel_err pulses the next cycle; the entry is still delivered.
- Storage is a main register (drives out_data) and a skid register. FSM states:
  - EMPTY: out_valid=0, in_ready=1. Accept → ONE.
  - ONE: main full, in_ready=1.
    - Accept & out → ONE; main takes the new value.
    - Accept & no out → TWO; new value goes to skid.
    - Out & no accept → EMPTY.
  - TWO: main and skid full, in_ready=0.
    - Out → ONE; skid moves to main.
    - Any in_valid is ignored (not accepted).
- Order is strictly FIFO; no entry is dropped or duplicated except by flush.
- Flush: the next state is EMPTY regardless of in_valid/out_ready. A concurrent in_valid is not captured, even though in_ready=1 was shown; flush wins. sel_err is not raised for a flushed-cycle input.
- While out_valid=1 and out_ready=0, out_data is held stable.
- Reset values: out_valid=0, in_ready=1, out_data=0, sel_err=0, FSM=EMPTY, skid register=0.
- Reset asserted mid-transfer discards all entries immediately (asynchronous). On release, the stage resumes from EMPTY on the first rising edge.

## Timing
- Latency: 1 cycle from an accepted input to out_valid when the stage was EMPTY, or was ONE with a simultaneous drain.
- Throughput: 1 transfer/cycle sustained while out_ready=1.
- in_ready and out_valid are pure flop outputs. in_ready deasserts the cycle after entering TWO and reasserts the cycle after leaving it.
- sel_err is asserted exactly one cycle after the offending accept edge, for one cycle.
- Worst combinational path: N:1 WIDTH-bit mux into the main or skid D-input.

## Structure
- Shared package (the team's common pipeline package) holds the state enum (ST_EMPTY, ST_ONE, ST_TWO). It is reused by other skid-buffered stages.
- One natural sub-module: muxn_comb, a combinational N:1 WIDTH-bit selector with out-of-range detect. It is also reusable standalone wherever a wider replacement for 2:1 selection is needed.

## Test plan
- Reset/idle: hold rst_n=0 for 3 cycles → out_valid=0, in_ready=1, out_data=0, sel_err=0; after release with in_valid=0 these stay unchanged.
- Streaming, N=4, WIDTH=32, out_ready=1: channels 0x11,0x22,0x33,0x44; sel=0,1,2,3 on consecutive cycles → out_data 0x11,0x22,0x33,0x44 on the following cycles. out_valid stays 1 throughout and in_ready never drops.
- Backpressure: accept A with out_ready=0, then B → state TWO, in_ready=0, out_data=A held. A third offer C is not accepted. With out_ready=1: A, then B, then C once accepted, with no loss.
- Out-of-range select, N=3: sel=3 with channel 0 = 0xDEAD → out_data=0xDEAD, and sel_err=1 for exactly one cycle, aligned with out_valid.
- Flush: in TWO, assert flush together with in_valid=1, D → next cycle out_valid=0, in_ready=1; D never appears at the output.
- Async reset mid-operation: in TWO, drop rst_n between edges → out_valid=0 immediately, before the next edge. After release, a single accept gives a single output.

Source files
------------

// File: rtl/muxn_pipe_stage_pkg.sv
// Common pipeline package: occupancy states shared by the skid-buffered stages.
package muxn_pipe_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage : muxn_pipe_stage_pkg

// File: rtl/muxn_pipe_stage_if.sv
// Handshake bundle for the N-way selection stage: input offer, flush and output stream.
interface muxn_pipe_stage_if #(
  parameter int WIDTH = 32,
  parameter int N     = 2
);
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]   sel;
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;

  modport master (
    output in_data, sel, in_valid, flush, out_ready,
    input  in_ready, out_data, out_valid, sel_err
  );

  modport slave (
    input  in_data, sel, in_valid, flush, out_ready,
    output in_ready, out_data, out_valid, sel_err
  );

endinterface : muxn_pipe_stage_if

// File: rtl/muxn_pipe_stage_muxn_comb.sv
// Combinational N:1 WIDTH-bit selector; an out-of-range select falls back to channel 0
// and raises sel_err.
module muxn_comb #(
  parameter int WIDTH = 32,
  parameter int N     = 2,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               sel_err
);

  always_comb begin
    out_data = in_data[WIDTH-1:0];
    sel_err  = 1'b1;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        out_data = in_data[k*WIDTH +: WIDTH];
        sel_err  = 1'b0;
      end
    end
  end

endmodule : muxn_comb

// File: rtl/muxn_pipe_stage.sv
// Registered N-way selection stage with valid/ready handshake and a two-entry skid buffer.
// in_ready and out_valid come straight from flops so no ready path crosses the stage.
module muxn_pipe_stage
  import muxn_pipe_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 2
) (
  input logic              clk,
  input logic              rst_n,
  muxn_pipe_stage_if.slave bus
);

  pipe_state_e      state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] sel_data;
  logic             range_err;
  logic             accept;
  logic             drain;

  muxn_comb #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_muxn_comb (
    .in_data  (bus.in_data),
    .sel      (bus.sel),
    .out_data (sel_data),
    .sel_err  (range_err)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = out_valid_q & bus.out_ready;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    sel_err_d   = 1'b0;

    // Flush overrides everything, including an input offered in the same cycle.
    if (bus.flush) begin
      state_d     = ST_EMPTY;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      sel_err_d = accept & range_err;
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d      = sel_data;
            state_d     = ST_ONE;
            out_valid_d = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_d = sel_data;
          end else if (accept) begin
            skid_d     = sel_data;
            state_d    = ST_TWO;
            in_ready_d = 1'b0;
          end else if (drain) begin
            state_d     = ST_EMPTY;
            out_valid_d = 1'b0;
          end
        end
        ST_TWO: begin
          if (drain) begin
            main_d     = skid_q;
            state_d    = ST_ONE;
            in_ready_d = 1'b1;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.sel_err   = sel_err_q;

endmodule : muxn_pipe_stage

// File: tb/tb_muxn_pipe_stage.sv
// Bench for muxn_pipe_stage: an N=4 and an N=3 instance driven with identical stimulus,
// checked every cycle against a queue model plus hand-computed literal expectations.
module tb_muxn_pipe_stage;

  typedef struct packed {
    logic [31:0] d4;
    logic [31:0] d3;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] ch [4];

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  ent_t mq[$];
  logic m_err4 = 1'b0;
  logic m_err3 = 1'b0;

  muxn_pipe_stage_if #(.WIDTH(32), .N(4)) if4 ();
  muxn_pipe_stage_if #(.WIDTH(32), .N(3)) if3 ();

  muxn_pipe_stage #(.WIDTH(32), .N(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if4.slave)
  );

  muxn_pipe_stage #(.WIDTH(32), .N(3)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3.slave)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp(name, act, exp);
  endtask

  task automatic setChannels(input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3);
    ch[0] = d0; ch[1] = d1; ch[2] = d2; ch[3] = d3;
    if4.in_data = {d3, d2, d1, d0};
    if3.in_data = {d2, d1, d0};
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic f, input logic r);
    in_valid = v; sel = s; flush = f; out_ready = r;
    if4.in_valid = v; if4.sel = s; if4.flush = f; if4.out_ready = r;
    if3.in_valid = v; if3.sel = s; if3.flush = f; if3.out_ready = r;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: a FIFO of at most two entries; an N=3 select of 3 falls back to channel 0.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_err4 = 1'b0;
      m_err3 = 1'b0;
    end else begin
      automatic bit   acc = in_valid && (mq.size() < 2);
      automatic bit   pop = (mq.size() > 0) && out_ready;
      automatic ent_t e;
      m_err4 = 1'b0;
      m_err3 = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        if (pop) mq.delete(0);
        if (acc) begin
          e.d4 = ch[sel];
          e.d3 = (sel < 2'd3) ? ch[sel] : ch[0];
          mq.push_back(e);
          m_err3 = (sel >= 2'd3);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("in_ready4",  {31'd0, if4.in_ready},  {31'd0, mq.size() < 2});
      cmp("out_valid4", {31'd0, if4.out_valid}, {31'd0, mq.size() > 0});
      cmp("sel_err4",   {31'd0, if4.sel_err},   {31'd0, m_err4});
      cmp("in_ready3",  {31'd0, if3.in_ready},  {31'd0, mq.size() < 2});
      cmp("out_valid3", {31'd0, if3.out_valid}, {31'd0, mq.size() > 0});
      cmp("sel_err3",   {31'd0, if3.sel_err},   {31'd0, m_err3});
      if (mq.size() > 0) begin
        cmp("out_data4", if4.out_data, mq[0].d4);
        cmp("out_data3", if3.out_data, mq[0].d3);
      end
    end
  end

  initial begin
    automatic logic [31:0] stream_exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

    setChannels(32'h0, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    step(1);
    chk_en = 1'b1;
    step(2);

    // Reset and idle
    checkOutput("rst_out_valid", {31'd0, if4.out_valid}, 32'd0);
    checkOutput("rst_in_ready",  {31'd0, if4.in_ready},  32'd1);
    checkOutput("rst_out_data",  if4.out_data, 32'h0);
    checkOutput("rst_sel_err",   {31'd0, if3.sel_err},   32'd0);
    rst_n = 1'b1;
    step(2);
    checkOutput("idle_out_valid", {31'd0, if4.out_valid}, 32'd0);
    checkOutput("idle_in_ready",  {31'd0, if4.in_ready},  32'd1);
    checkOutput("idle_out_data",  if4.out_data, 32'h0);

    // Streaming at full rate
    setChannels(32'h11, 32'h22, 32'h33, 32'h44);
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b1, 2'(s), 1'b0, 1'b1);
      step(1);
      checkOutput("stream_data",  if4.out_data, stream_exp[s]);
      checkOutput("stream_valid", {31'd0, if4.out_valid}, 32'd1);
      checkOutput("stream_ready", {31'd0, if4.in_ready},  32'd1);
    end
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    step(1);
    checkOutput("stream_drained", {31'd0, if4.out_valid}, 32'd0);

    // Backpressure fills the skid; third offer is refused
    setChannels(32'h0000_000C, 32'h0000_000A, 32'h0000_000B, 32'h0);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    step(1);
    checkOutput("bp_a", if4.out_data, 32'hA);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b0);
    step(1);
    checkOutput("bp_two_ready", {31'd0, if4.in_ready}, 32'd0);
    checkOutput("bp_two_hold",  if4.out_data, 32'hA);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    step(1);
    checkOutput("bp_c_refused", {31'd0, if4.in_ready}, 32'd0);
    checkOutput("bp_hold_a",    if4.out_data, 32'hA);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b1);
    step(1);
    checkOutput("bp_b", if4.out_data, 32'hB);
    checkOutput("bp_ready_back", {31'd0, if4.in_ready}, 32'd1);
    step(1);
    checkOutput("bp_c", if4.out_data, 32'hC);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    step(1);
    checkOutput("bp_empty", {31'd0, if4.out_valid}, 32'd0);

    // Out-of-range select on the N=3 instance
    setChannels(32'hDEAD, 32'h1, 32'h2, 32'hBEEF);
    applyStimulus(1'b1, 2'd3, 1'b0, 1'b1);
    step(1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("oor_data3",  if3.out_data, 32'hDEAD);
    checkOutput("oor_err3",   {31'd0, if3.sel_err},   32'd1);
    checkOutput("oor_valid3", {31'd0, if3.out_valid}, 32'd1);
    checkOutput("oor_data4",  if4.out_data, 32'hBEEF);
    checkOutput("oor_err4",   {31'd0, if4.sel_err},   32'd0);
    step(1);
    checkOutput("oor_err3_end", {31'd0, if3.sel_err}, 32'd0);

    // Flush while full, with a concurrent offer
    setChannels(32'h1, 32'h2, 32'h3, 32'h4);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    step(1);
    setChannels(32'hD, 32'hD, 32'hD, 32'hD);
    applyStimulus(1'b1, 2'd3, 1'b1, 1'b0);
    step(1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("flush_valid",  {31'd0, if4.out_valid}, 32'd0);
    checkOutput("flush_ready",  {31'd0, if4.in_ready},  32'd1);
    checkOutput("flush_no_err", {31'd0, if3.sel_err},   32'd0);
    step(3);
    checkOutput("flush_no_d", {31'd0, if4.out_valid}, 32'd0);

    // Asynchronous reset while full
    setChannels(32'h5, 32'h6, 32'h7, 32'h8);
    applyStimulus(1'b1, 2'd0, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b1, 2'd1, 1'b0, 1'b0);
    step(1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid_now", {31'd0, if4.out_valid}, 32'd0);
    checkOutput("arst_ready_now", {31'd0, if4.in_ready},  32'd1);
    step(2);
    rst_n = 1'b1;
    setChannels(32'h0, 32'h0, 32'h77, 32'h0);
    applyStimulus(1'b1, 2'd2, 1'b0, 1'b1);
    step(1);
    applyStimulus(1'b0, 2'd0, 1'b0, 1'b1);
    checkOutput("arst_single", if4.out_data, 32'h77);
    checkOutput("arst_single_valid", {31'd0, if4.out_valid}, 32'd1);
    step(1);
    checkOutput("arst_single_once", {31'd0, if4.out_valid}, 32'd0);
    step(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_muxn_pipe_stage
